memory_control_arb: RTL and testbench

Memory controller sitting directly downstream of every per-CPU icache and dcache. It arbitrates their miss/writeback requests onto the single RAM port and returns data with per-requester wait signals. It is a registered-grant FSM: data accesses take priority over instruction fetches, and CPUs are served round-robin within each class. Its outputs are the `iwait`/`iload`/`dwait`/`dload` members of `cache_control_if` that the caches consume.

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/memctl_rr_arbiter.sv | 27 ++
 rtl/memory_control_arb.sv | 160 ++++++++++++++++
 tb/tb_memory_control_arb.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM handshake states, machine word and memory-controller FSM states.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE,
        IREAD,
        DREAD,
        DWRITE
    } memctl_state_t;

endpackage

// File: rtl/memctl_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping modulo CPUS.
module memctl_rr_arbiter #(
    parameter int unsigned CPUS = 2,
    parameter int unsigned GW   = 1
) (
    input  logic [CPUS-1:0] req,
    input  logic [GW-1:0]   ptr,
    output logic [GW-1:0]   idx,
    output logic            valid
);

    logic [GW-1:0] cand;

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < CPUS; k++) begin
            cand = GW'((32'(ptr) + k) % CPUS);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/memory_control_arb.sv
// Arbitrates per-CPU icache/dcache requests onto the single RAM port; data class beats instruction class.
// Optional access/stall counters are built when MEMCTL_STATS_EN is defined.
module memory_control_arb
    import cpu_types_pkg::*;
#(
    parameter int unsigned CPUS = 2
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic [CPUS-1:0]              iREN,
    input  logic [CPUS-1:0][WORD_W-1:0]  iaddr,
    input  logic [CPUS-1:0]              dREN,
    input  logic [CPUS-1:0]              dWEN,
    input  logic [CPUS-1:0][WORD_W-1:0]  daddr,
    input  logic [CPUS-1:0][WORD_W-1:0]  dstore,
    output logic [CPUS-1:0]              iwait,
    output logic [CPUS-1:0][WORD_W-1:0]  iload,
    output logic [CPUS-1:0]              dwait,
    output logic [CPUS-1:0][WORD_W-1:0]  dload,
    output logic                         ramREN,
    output logic                         ramWEN,
    output logic [WORD_W-1:0]            ramaddr,
    output logic [WORD_W-1:0]            ramstore,
    input  logic [WORD_W-1:0]            ramload,
    input  ramstate_t                    ramstate
`ifdef MEMCTL_STATS_EN
   ,output logic [WORD_W-1:0]            stat_iacc,
    output logic [WORD_W-1:0]            stat_dacc,
    output logic [WORD_W-1:0]            stat_stall
`endif
);

    localparam int unsigned GW = (CPUS > 1) ? $clog2(CPUS) : 1;

    memctl_state_t state, next_state;
    logic [GW-1:0] gnt, gnt_n, rr_ptr, rr_n, gnt_inc;
    logic [GW-1:0] d_idx, i_idx;
    logic          d_valid, i_valid;
    logic [CPUS-1:0] d_req;

    assign d_req   = dREN | dWEN;
    assign gnt_inc = (gnt == GW'(CPUS - 1)) ? '0 : gnt + GW'(1);

    memctl_rr_arbiter #(.CPUS(CPUS), .GW(GW)) u_darb (
        .req   (d_req),
        .ptr   (rr_ptr),
        .idx   (d_idx),
        .valid (d_valid)
    );

    memctl_rr_arbiter #(.CPUS(CPUS), .GW(GW)) u_iarb (
        .req   (iREN),
        .ptr   (rr_ptr),
        .idx   (i_idx),
        .valid (i_valid)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            gnt    <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= next_state;
            gnt    <= gnt_n;
            rr_ptr <= rr_n;
        end
    end

    // RAM port follows the granted requester's live request; a dropped request aborts silently.
    always_comb begin
        next_state = state;
        gnt_n      = gnt;
        rr_n       = rr_ptr;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iwait      = '1;
        dwait      = '1;
        iload      = '0;
        dload      = '0;
        case (state)
            IDLE: begin
                if (d_valid) begin
                    gnt_n      = d_idx;
                    next_state = dWEN[d_idx] ? DWRITE : DREAD;
                end else if (i_valid) begin
                    gnt_n      = i_idx;
                    next_state = IREAD;
                end
            end
            IREAD: begin
                if (!iREN[gnt]) begin
                    next_state = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr[gnt];
                    if (ramstate == ACCESS) begin
                        iwait[gnt] = 1'b0;
                        iload[gnt] = ramload;
                        rr_n       = gnt_inc;
                        next_state = IDLE;
                    end
                end
            end
            DREAD: begin
                if (!dREN[gnt]) begin
                    next_state = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = daddr[gnt];
                    if (ramstate == ACCESS) begin
                        dwait[gnt] = 1'b0;
                        dload[gnt] = ramload;
                        rr_n       = gnt_inc;
                        next_state = IDLE;
                    end
                end
            end
            DWRITE: begin
                if (!dWEN[gnt]) begin
                    next_state = IDLE;
                end else begin
                    ramWEN   = 1'b1;
                    ramaddr  = daddr[gnt];
                    ramstore = dstore[gnt];
                    if (ramstate == ACCESS) begin
                        dwait[gnt] = 1'b0;
                        dload[gnt] = ramload;
                        rr_n       = gnt_inc;
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

`ifdef MEMCTL_STATS_EN
    logic i_done, d_done, stall;

    assign i_done = ~&iwait;
    assign d_done = ~&dwait;
    assign stall  = (state != IDLE) && (ramstate != ACCESS);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_iacc  <= '0;
            stat_dacc  <= '0;
            stat_stall <= '0;
        end else begin
            stat_iacc  <= stat_iacc + WORD_W'(i_done);
            stat_dacc  <= stat_dacc + WORD_W'(d_done);
            stat_stall <= stat_stall + WORD_W'(stall);
        end
    end
`endif

endmodule

// File: tb/tb_memory_control_arb.sv
// Scoreboard bench for memory_control_arb: directed requests push expected completions, a monitor checks them.
module tb_memory_control_arb;
    import cpu_types_pkg::*;

    localparam int unsigned CPUS = 2;

    logic                   CLK, nRST;
    logic [CPUS-1:0]        iREN, dREN, dWEN, iwait, dwait;
    logic [CPUS-1:0][31:0]  iaddr, daddr, dstore, iload, dload;
    logic                   ramREN, ramWEN;
    logic [31:0]            ramaddr, ramstore, ramload;
    ramstate_t              ramstate;
`ifdef MEMCTL_STATS_EN
    logic [31:0]            stat_iacc, stat_dacc, stat_stall;
`endif

    memory_control_arb #(.CPUS(CPUS)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .iload(iload), .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
`ifdef MEMCTL_STATS_EN
       ,.stat_iacc(stat_iacc), .stat_dacc(stat_dacc), .stat_stall(stat_stall)
`endif
    );

    typedef struct {
        bit          is_d;
        int          cpu;
        logic [31:0] addr;
        bit          wen;
        logic [31:0] store;
        logic [31:0] load;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    task automatic push(input bit is_d, input int cpu, input logic [31:0] addr,
                        input bit wen, input logic [31:0] store, input logic [31:0] load);
        exp_t e;
        e.is_d = is_d; e.cpu = cpu; e.addr = addr;
        e.wen = wen; e.store = store; e.load = load;
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_done(input bit is_d, input int cpu, input int budget);
        bit seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge CLK);
            if ((is_d ? dwait[cpu] : iwait[cpu]) == 1'b0) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL wait_done_%s%0d actual=timeout required=completion within %0d cycles",
                     is_d ? "d" : "i", cpu, budget);
        end
    endtask

    task automatic score(input bit is_d, input int c);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected actual=%s completion cpu%0d required=none",
                     is_d ? "data" : "ifetch", c);
        end else begin
            e = sb.pop_front();
            chk("sb_class", 32'(is_d), 32'(e.is_d));
            chk("sb_cpu", c, e.cpu);
            chk("sb_load", is_d ? dload[c] : iload[c], e.load);
            chk("sb_addr", ramaddr, e.addr);
            chk("sb_wen", 32'(ramWEN), 32'(e.wen));
            chk("sb_ren", 32'(ramREN), 32'(!e.wen));
            if (e.wen) chk("sb_store", ramstore, e.store);
        end
    endtask

    // Monitor: every completion (wait low) must match the oldest expected access.
    always @(negedge CLK) begin
        if (nRST === 1'b1) begin
            for (int c = 0; c < int'(CPUS); c++) begin
                if (iwait[c] === 1'b0) score(1'b0, c);
                if (dwait[c] === 1'b0) score(1'b1, c);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        CLK = 1'b0; nRST = 1'b0;
        iREN = '0; dREN = '0; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramload = '0; ramstate = FREE;

        // Reset state
        @(negedge CLK);
        chk("rst_iwait", 32'(iwait), 32'h3);
        chk("rst_dwait", 32'(dwait), 32'h3);
        chk("rst_iload", iload[0] | iload[1], 32'h0);
        chk("rst_dload", dload[0] | dload[1], 32'h0);
        chk("rst_ramen", {30'd0, ramREN, ramWEN}, 32'h0);
        chk("rst_ramaddr", ramaddr, 32'h0);
        chk("rst_ramstore", ramstore, 32'h0);
        cyc();
        nRST = 1'b1;

        // Single ifetch, minimum latency
        cyc();
        iREN[0] = 1'b1; iaddr[0] = 32'h40; ramstate = ACCESS; ramload = 32'hDEADBEEF;
        push(1'b0, 0, 32'h40, 1'b0, 32'h0, 32'hDEADBEEF);
        @(negedge CLK);
        chk("t1_idle_ren", 32'(ramREN), 32'h0);
        chk("t1_idle_iwait", 32'(iwait), 32'h3);
        cyc();
        @(negedge CLK);
        chk("t1_ren", 32'(ramREN), 32'h1);
        chk("t1_addr", ramaddr, 32'h40);
        chk("t1_iwait", 32'(iwait), 32'h2);
        cyc();
        iREN = '0;
        @(negedge CLK);
        chk("t1_after_iwait", 32'(iwait), 32'h3);
        chk("t1_after_iload", iload[0], 32'h0);

        // Priority: data beats instruction
        cyc();
        iREN[0] = 1'b1; iaddr[0] = 32'h100;
        dREN[1] = 1'b1; daddr[1] = 32'h200; ramload = 32'hAAAA0001;
        push(1'b1, 1, 32'h200, 1'b0, 32'h0, 32'hAAAA0001);
        push(1'b0, 0, 32'h100, 1'b0, 32'h0, 32'hBBBB0002);
        wait_done(1'b1, 1, 5);
        cyc();
        dREN[1] = 1'b0; ramload = 32'hBBBB0002;
        wait_done(1'b0, 0, 5);
        cyc();
        iREN = '0; ramload = '0;

        // Fresh reset so the round-robin pointer starts at CPU0
        nRST = 1'b0;
        cyc();
        nRST = 1'b1;
        cyc();

        // Round-robin writes
        dWEN = 2'b11;
        daddr[0] = 32'h300; dstore[0] = 32'hC0C00000;
        daddr[1] = 32'h304; dstore[1] = 32'hC1C10001;
        ramstate = ACCESS;
        for (int k = 0; k < 4; k++)
            push(1'b1, k % 2, (k % 2) ? 32'h304 : 32'h300, 1'b1,
                 (k % 2) ? 32'hC1C10001 : 32'hC0C00000, 32'h0);
        for (int k = 0; k < 4; k++) wait_done(1'b1, k % 2, 6);
        cyc();
        dWEN = '0;

        // BUSY/ERROR stretch on a data read
        dREN[0] = 1'b1; daddr[0] = 32'h500; ramstate = FREE;
        push(1'b1, 0, 32'h500, 1'b0, 32'h0, 32'h5A5A5A5A);
        @(negedge CLK);
        cyc(); ramstate = BUSY;
        @(negedge CLK);
        chk("t4_busy_dwait", 32'(dwait), 32'h3);
        chk("t4_busy_ren", 32'(ramREN), 32'h1);
        cyc(); ramstate = ERROR;
        @(negedge CLK);
        chk("t4_err_dwait", 32'(dwait), 32'h3);
        cyc(); ramstate = BUSY;
        @(negedge CLK);
        chk("t4_busy2_dwait", 32'(dwait), 32'h3);
        cyc(); ramstate = ACCESS; ramload = 32'h5A5A5A5A;
        @(negedge CLK);
        chk("t4_done_dwait", 32'(dwait), 32'h2);
        cyc();
        dREN = '0; ramload = '0;
`ifdef MEMCTL_STATS_EN
        chk("stat_stall", stat_stall, 32'd3);
        chk("stat_dacc", stat_dacc, 32'd5);
        chk("stat_iacc", stat_iacc, 32'd0);
`endif

        // Abort: CPU1 drops its ifetch mid-service (pointer is 1, so an advance would make it 0)
        iREN[1] = 1'b1; iaddr[1] = 32'h600; ramstate = BUSY;
        @(negedge CLK);
        cyc();
        @(negedge CLK);
        chk("t5_ren", 32'(ramREN), 32'h1);
        chk("t5_addr", ramaddr, 32'h600);
        chk("t5_iwait", 32'(iwait), 32'h3);
        cyc();
        iREN = '0;
        @(negedge CLK);
        chk("t5_abort_ren", 32'(ramREN), 32'h0);
        chk("t5_abort_iwait", 32'(iwait), 32'h3);
        cyc();
        // Pointer unchanged: simultaneous data reads serve CPU1 first
        dREN = 2'b11; daddr[0] = 32'h700; daddr[1] = 32'h704;
        ramstate = ACCESS; ramload = 32'h77770001;
        push(1'b1, 1, 32'h704, 1'b0, 32'h0, 32'h77770001);
        push(1'b1, 0, 32'h700, 1'b0, 32'h0, 32'h77770000);
        wait_done(1'b1, 1, 6);
        cyc();
        dREN[1] = 1'b0; ramload = 32'h77770000;
        wait_done(1'b1, 0, 6);
        cyc();
        dREN = '0; ramload = '0;

        // Reset mid-DWRITE; dWEN wins over a same-CPU dREN
        dWEN[0] = 1'b1; dREN[0] = 1'b1; daddr[0] = 32'h800; dstore[0] = 32'h88;
        ramstate = BUSY;
        @(negedge CLK);
        cyc();
        @(negedge CLK);
        chk("t6_wen", 32'(ramWEN), 32'h1);
        chk("t6_ren", 32'(ramREN), 32'h0);
        chk("t6_addr", ramaddr, 32'h800);
        chk("t6_store", ramstore, 32'h88);
        #1 nRST = 1'b0;
        #1 chk("t6_async_wen", 32'(ramWEN), 32'h0);
        dWEN = '0; dREN = '0;
        cyc();
        cyc();
        nRST = 1'b1;
        @(negedge CLK);
        chk("t6_post_iwait", 32'(iwait), 32'h3);
        chk("t6_post_dwait", 32'(dwait), 32'h3);
        chk("t6_post_ramen", {30'd0, ramREN, ramWEN}, 32'h0);
`ifdef MEMCTL_STATS_EN
        chk("t6_stat_dacc", stat_dacc, 32'd0);
`endif
        cyc();

        chk("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
